// File: rtl/ssd_pkg.sv
// Shared constants and helpers for the seven-segment scan controller.
package ssd_pkg;

    localparam int SSD_NIB_W   = 4;
    localparam int SSD_MAX_DIG = 32;
    localparam logic [SSD_NIB_W-1:0] SSD_OFF_NIB = 4'h0;

    // Ceiling log2, never below 1 so counters always have at least one bit.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic logic [SSD_MAX_DIG-1:0] ssd_onecold(input int idx, input int n);
        logic [SSD_MAX_DIG-1:0] r;
        r = '1;
        if (idx < n) begin
            r[idx] = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/ssd_tick_gen.sv
// Scan prescaler: one-cycle tick every DIV clocks.
module ssd_tick_gen
    import ssd_pkg::*;
#(
    parameter int unsigned DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int W = clog2(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] presc;

    assign tick = (presc == LAST);

    always_ff @(posedge clk) begin
        if (rst || tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Time-multiplexed N-digit seven-segment scan driver with per-frame shadow latching.
// Define SSD_LZB_EN to enable leading-zero blanking on the shadow digits.
module ssd_scan_ctrl
    import ssd_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en,
    input  logic [SSD_NIB_W*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]           blank_mask,
    input  logic [NUM_DIGITS-1:0]           blink_mask,
    input  logic [NUM_DIGITS-1:0]           dp_mask,
    output logic [NUM_DIGITS-1:0]           ssd_ctl,
    output logic [SSD_NIB_W-1:0]            ssd_in,
    output logic                            ssd_dp,
    output logic                            frame_done
);

    localparam int IDX_W = clog2(NUM_DIGITS);
    localparam int FRM_W = clog2(BLINK_FRAMES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    logic                            tick;
    logic                            wrap;
    logic                            load;
    logic                            init;
    logic                            blink_phase;
    logic                            off;
    logic [IDX_W-1:0]                idx;
    logic [FRM_W-1:0]                frame_cnt;
    logic [SSD_NIB_W*NUM_DIGITS-1:0] sh_digits;
    logic [NUM_DIGITS-1:0]           sh_blank;
    logic [NUM_DIGITS-1:0]           sh_blink;
    logic [NUM_DIGITS-1:0]           sh_dp;
    logic [NUM_DIGITS-1:0]           lzb;
    logic [SSD_MAX_DIG-1:0]          ctl_full;

    ssd_tick_gen #(
        .DIV (SCAN_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign wrap = tick && (idx == IDX_LAST);
    assign load = wrap || init;

`ifdef SSD_LZB_EN
    // Walk down from the leftmost digit; blanking stops at the first non-zero nibble.
    always_comb begin
        logic zrun;
        lzb  = '0;
        zrun = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zrun   = zrun && (sh_digits[SSD_NIB_W*i +: SSD_NIB_W] == '0);
            lzb[i] = zrun;
        end
    end
`else
    assign lzb = '0;
`endif

    assign off = !en || sh_blank[idx] || (sh_blink[idx] && blink_phase) || lzb[idx];
    assign ctl_full = ssd_onecold(int'(idx), NUM_DIGITS);

    always_ff @(posedge clk) begin
        if (rst) begin
            idx         <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            init        <= 1'b1;
            sh_digits   <= '0;
            sh_blank    <= '0;
            sh_blink    <= '0;
            sh_dp       <= '0;
            ssd_ctl     <= '1;
            ssd_in      <= SSD_OFF_NIB;
            ssd_dp      <= 1'b1;
            frame_done  <= 1'b0;
        end else begin
            init       <= 1'b0;
            frame_done <= wrap;
            if (tick) begin
                idx <= wrap ? '0 : idx + 1'b1;
            end
            if (load) begin
                sh_digits <= digits;
                sh_blank  <= blank_mask;
                sh_blink  <= blink_mask;
                sh_dp     <= dp_mask;
            end
            if (wrap) begin
                if (frame_cnt == FRM_LAST) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
            if (off) begin
                ssd_ctl <= '1;
                ssd_in  <= SSD_OFF_NIB;
                ssd_dp  <= 1'b1;
            end else begin
                ssd_ctl <= ctl_full[NUM_DIGITS-1:0];
                ssd_in  <= sh_digits[SSD_NIB_W*idx +: SSD_NIB_W];
                ssd_dp  <= ~sh_dp[idx];
            end
        end
    end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Scoreboard bench for ssd_scan_ctrl: a cycle-count reference model predicts every output cycle.
module tb_ssd_scan_ctrl;

    localparam int N   = 4;
    localparam int DIV = 4;
    localparam int BF  = 2;
    localparam int F   = N * DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] digits;
    logic [3:0]  blank_mask;
    logic [3:0]  blink_mask;
    logic [3:0]  dp_mask;
    logic [3:0]  ssd_ctl;
    logic [3:0]  ssd_in;
    logic        ssd_dp;
    logic        frame_done;

    always #5 clk = ~clk;

    ssd_scan_ctrl #(
        .NUM_DIGITS   (N),
        .SCAN_DIV     (DIV),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .digits     (digits),
        .blank_mask (blank_mask),
        .blink_mask (blink_mask),
        .dp_mask    (dp_mask),
        .ssd_ctl    (ssd_ctl),
        .ssd_in     (ssd_in),
        .ssd_dp     (ssd_dp),
        .frame_done (frame_done)
    );

    typedef struct packed {
        logic [3:0] ctl;
        logic [3:0] nib;
        logic       dp;
        logic       fd;
    } exp_t;

    exp_t expq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Model state: cycles since reset release and the values latched for the current frame.
    int          m_t = 0;
    logic [15:0] m_dig;
    logic [3:0]  m_blank, m_blink, m_dp;

    function automatic bit lzb_ref(input logic [15:0] d, input int i);
        bit use_lzb;
        use_lzb = 1'b0;
`ifdef SSD_LZB_EN
        use_lzb = 1'b1;
`endif
        return use_lzb && (i > 0) && ((d >> (4 * i)) == 16'h0);
    endfunction

    // Reference model: predicts the outputs that follow each rising edge.
    initial begin
        exp_t e;
        int   idx;
        int   frame;
        bit   phase;
        bit   off;
        forever begin
            @(posedge clk);
            if (rst) begin
                e       = '{ctl: 4'hF, nib: 4'h0, dp: 1'b1, fd: 1'b0};
                m_t     = 0;
                m_dig   = '0;
                m_blank = '0;
                m_blink = '0;
                m_dp    = '0;
            end else begin
                idx   = (m_t / DIV) % N;
                frame = m_t / F;
                phase = ((frame / BF) % 2) == 1;
                off   = !en || m_blank[idx] || (m_blink[idx] && phase) || lzb_ref(m_dig, idx);
                e.ctl = off ? 4'hF : ~(4'b0001 << idx);
                e.nib = off ? 4'h0 : m_dig[idx*4 +: 4];
                e.dp  = off ? 1'b1 : ~m_dp[idx];
                e.fd  = (m_t % F) == (F - 1);
                if (m_t == 0 || (m_t % F) == (F - 1)) begin
                    m_dig   = digits;
                    m_blank = blank_mask;
                    m_blink = blink_mask;
                    m_dp    = dp_mask;
                end
                m_t++;
            end
            expq.push_back(e);
        end
    end

    // Monitor: compares DUT outputs mid-cycle against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                n_checks += 4;
                if (ssd_ctl !== e.ctl) begin
                    n_fail++;
                    $display("FAIL ssd_ctl @%0t: got %b want %b", $time, ssd_ctl, e.ctl);
                end
                if (ssd_in !== e.nib) begin
                    n_fail++;
                    $display("FAIL ssd_in @%0t: got %h want %h", $time, ssd_in, e.nib);
                end
                if (ssd_dp !== e.dp) begin
                    n_fail++;
                    $display("FAIL ssd_dp @%0t: got %b want %b", $time, ssd_dp, e.dp);
                end
                if (frame_done !== e.fd) begin
                    n_fail++;
                    $display("FAIL frame_done @%0t: got %b want %b", $time, frame_done, e.fd);
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Advance until the coming cycle sits at the given offset within a frame.
    task automatic wait_frame_pos(input int pos);
        for (int k = 0; k < F; k++) begin
            if ((m_t % F) == pos) return;
            cycles(1);
        end
        n_checks++;
        n_fail++;
        $display("FAIL frame_pos_wait: got offset %0d want %0d", m_t % F, pos);
    endtask

    initial begin
        rst        = 1'b1;
        en         = 1'b1;
        digits     = 16'h1234;
        blank_mask = '0;
        blink_mask = '0;
        dp_mask    = '0;
        cycles(3);
        rst = 1'b0;
        cycles(40);

        wait_frame_pos(DIV + 1);
        digits = 16'h5678;
        cycles(40);

        blink_mask = 4'b0011;
        cycles(140);
        blink_mask = '0;

        blank_mask = 4'b0100;
        dp_mask    = 4'b0110;
        cycles(40);
        en = 1'b0;
        cycles(40);
        en         = 1'b1;
        blank_mask = '0;

        digits = 16'h0007;
        cycles(40);
        digits = 16'h0000;
        cycles(40);
        digits = 16'h0500;
        cycles(40);
        digits = 16'hAF0C;
        cycles(40);

        wait_frame_pos(2 * DIV + 1);
        rst = 1'b1;
        cycles(1);
        rst    = 1'b0;
        digits = 16'h4321;
        cycles(40);

        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                for (int j = 0; j < 4; j++) begin
                    digits[j*4 +: 4] = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
                end
            end
            if ($urandom_range(0, 15) == 0) blank_mask = 4'($urandom);
            if ($urandom_range(0, 15) == 0) blink_mask = 4'($urandom);
            if ($urandom_range(0, 15) == 0) dp_mask = 4'($urandom);
            en  = ($urandom_range(0, 15) != 0);
            rst = ($urandom_range(0, 199) == 0);
            cycles(1);
        end
        rst = 1'b0;
        cycles(20);
        repeat (2) @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
